// File: rtl/vga_pkg.sv
// 1024x768@60 (65 MHz) raster constants shared by the timing source and its consumers.
package vga_pkg;

  localparam int CNT_W    = 11;
  localparam int RGB_W    = 12;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width versions of the window bounds; sync ends are inclusive.
  localparam logic [CNT_W-1:0] H_MAX        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLNK_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_MAX        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_BLNK_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

endpackage

// File: rtl/vga_if.sv
// Pixel stream passed from the timing source through the draw/overlay stages.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             hblnk;
  logic             vsync;
  logic             vblnk;
  logic [RGB_W-1:0] rgb;

  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// Raster counter and sync/blank decoder; sources a blank (black) vga_if stream.
module vga_timing
  import vga_pkg::*;
#(
  parameter logic HSYNC_ACTIVE = 1'b1,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_if.out          vga_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vsync_q, vsync_d;
  logic             vblnk_q, vblnk_d;
  logic [RGB_W-1:0] rgb_q;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             h_wrap, v_wrap;

  // Sync/blank are decoded from the next counter values so they land in the
  // same cycle as the position they describe.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    hblnk_d       = hblnk_q;
    vsync_d       = vsync_q;
    vblnk_d       = vblnk_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    h_wrap        = (hcount_q == H_MAX);
    v_wrap        = (vcount_q == V_MAX);
    if (en) begin
      hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end
      hblnk_d = (hcount_d >= H_BLNK_START);
      vblnk_d = (vcount_d >= V_BLNK_START);
      hsync_d = ((hcount_d >= H_SYNC_START) && (hcount_d <= H_SYNC_END))
                ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync_d = ((vcount_d >= V_SYNC_START) && (vcount_d <= V_SYNC_END))
                ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      if (h_wrap && v_wrap) begin
        frame_start_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HSYNC_ACTIVE;
      hblnk_q       <= 1'b0;
      vsync_q       <= ~VSYNC_ACTIVE;
      vblnk_q       <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      rgb_q         <= '0;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;
  assign frame_start    = frame_start_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed checks of vga_timing: first line, hold, vertical window, frame wrap, mid-frame reset.
module tb_vga_timing;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        frame_start, frame_start_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  int          total = 0;
  int          bad   = 0;

  vga_if vif ();
  vga_if vif_n ();

  vga_timing dut (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing #(.HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif_n),
    .frame_start(frame_start_n), .frame_cnt(frame_cnt_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Park the raster at a chosen position while en=0 so the held register
  // takes the forced value; the next enabled edge advances from (h, v).
  task automatic preload(input int h, input int v, input int fc);
    @(negedge clk);
    en = 1'b0;
    force dut.hcount_q    = 11'(h);
    force dut.vcount_q    = 11'(v);
    force dut.frame_cnt_q = 16'(fc);
    @(posedge clk);
    #1;
    release dut.hcount_q;
    release dut.vcount_q;
    release dut.frame_cnt_q;
    en = 1'b1;
  endtask

  initial begin
    int e_h, e_v, e_hb, e_hs, e_pol, hs_cnt, vs_cnt, e_vb, e_vs, e_frz;
    int eh, ev;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hcount", 32'(vif.hcount), 0);
    chk("rst_vcount", 32'(vif.vcount), 0);
    chk("rst_hblnk", 32'(vif.hblnk), 0);
    chk("rst_vblnk", 32'(vif.vblnk), 0);
    chk("rst_hsync", 32'(vif.hsync), 0);
    chk("rst_vsync", 32'(vif.vsync), 0);
    chk("rst_rgb", 32'(vif.rgb), 0);
    chk("rst_fstart", 32'(frame_start), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    chk("rst_hsync_inv", 32'(vif_n.hsync), 1);
    chk("rst_vsync_inv", 32'(vif_n.vsync), 1);

    // First line from reset: both polarities run in lockstep.
    rst = 1'b0;
    en  = 1'b1;
    e_h = 0; e_v = 0; e_hb = 0; e_hs = 0; e_pol = 0; hs_cnt = 0;
    for (int i = 1; i <= 1344; i++) begin
      @(posedge clk);
      #1;
      eh = i % 1344;
      ev = (i == 1344) ? 1 : 0;
      if (i == 1) chk("first_hcount", 32'(vif.hcount), 1);
      if (i == 1024) chk("hblnk_rise_1024", 32'(vif.hblnk), 1);
      if (i == 1023) chk("hblnk_low_1023", 32'(vif.hblnk), 0);
      if (i == 1344) chk("vcount_step_at_wrap", 32'(vif.vcount), 1);
      if (32'(vif.hcount) != 32'(eh)) e_h++;
      if (32'(vif.vcount) != 32'(ev)) e_v++;
      if (vif.hblnk !== (eh >= 1024)) e_hb++;
      if (vif.hsync !== (eh >= 1048 && eh <= 1183)) e_hs++;
      if (vif_n.hsync !== !(eh >= 1048 && eh <= 1183)) e_pol++;
      if (vif_n.vsync !== 1'b1) e_pol++;
      if (vif.hsync) hs_cnt++;
    end
    chk("line_hcount_errs", 32'(e_h), 0);
    chk("line_vcount_errs", 32'(e_v), 0);
    chk("line_hblnk_errs", 32'(e_hb), 0);
    chk("line_hsync_errs", 32'(e_hs), 0);
    chk("line_inv_sync_errs", 32'(e_pol), 0);
    chk("hsync_cycles", 32'(hs_cnt), 136);

    // Hold at (500, 300) for 100 cycles.
    preload(499, 300, 0);
    @(posedge clk);
    #1;
    chk("hold_start_h", 32'(vif.hcount), 500);
    chk("hold_start_v", 32'(vif.vcount), 300);
    en = 1'b0;
    e_frz = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (vif.hcount !== 11'd500 || vif.vcount !== 11'd300) e_frz++;
      if (vif.hsync !== 1'b0 || vif.hblnk !== 1'b0) e_frz++;
      if (vif.vsync !== 1'b0 || vif.vblnk !== 1'b0) e_frz++;
      if (frame_start !== 1'b0 || frame_cnt !== 16'd0) e_frz++;
    end
    chk("hold_frozen_errs", 32'(e_frz), 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_h", 32'(vif.hcount), 501);
    chk("resume_v", 32'(vif.vcount), 300);

    // Vertical window: lines 765..779.
    preload(1343, 764, 0);
    e_vb = 0; e_vs = 0; vs_cnt = 0;
    eh = 1343; ev = 764;
    for (int i = 0; i < 15 * 1344; i++) begin
      @(posedge clk);
      #1;
      if (eh == 1343) begin
        eh = 0;
        ev = ev + 1;
      end else begin
        eh = eh + 1;
      end
      if (vif.vblnk !== (ev >= 768)) e_vb++;
      if (vif.vsync !== (ev >= 771 && ev <= 776)) e_vs++;
      if (32'(vif.vcount) != 32'(ev) || 32'(vif.hcount) != 32'(eh)) e_vs++;
      if (vif.vsync) vs_cnt++;
    end
    chk("vblnk_errs", 32'(e_vb), 0);
    chk("vsync_errs", 32'(e_vs), 0);
    chk("vsync_cycles", 32'(vs_cnt), 8064);

    // Frame wrap with an ordinary count, then the 65535 rollover.
    preload(1342, 805, 0);
    @(posedge clk);
    #1;
    chk("pre_wrap_fstart", 32'(frame_start), 0);
    chk("pre_wrap_h", 32'(vif.hcount), 1343);
    @(posedge clk);
    #1;
    chk("wrap_h", 32'(vif.hcount), 0);
    chk("wrap_v", 32'(vif.vcount), 0);
    chk("wrap_fstart", 32'(frame_start), 1);
    chk("wrap_fcnt", 32'(frame_cnt), 1);
    @(posedge clk);
    #1;
    chk("post_wrap_fstart", 32'(frame_start), 0);
    chk("post_wrap_fcnt", 32'(frame_cnt), 1);

    preload(1343, 805, 65535);
    @(posedge clk);
    #1;
    chk("roll_fstart", 32'(frame_start), 1);
    chk("roll_fcnt", 32'(frame_cnt), 0);

    // Mid-frame reset at (700, 400).
    preload(699, 400, 9);
    @(posedge clk);
    #1;
    chk("mid_h", 32'(vif.hcount), 700);
    chk("mid_fcnt", 32'(frame_cnt), 9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_h", 32'(vif.hcount), 0);
    chk("mid_rst_v", 32'(vif.vcount), 0);
    chk("mid_rst_hsync", 32'(vif.hsync), 0);
    chk("mid_rst_vsync", 32'(vif.vsync), 0);
    chk("mid_rst_fcnt", 32'(frame_cnt), 0);
    chk("mid_rst_fstart", 32'(frame_start), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_rst_h", 32'(vif.hcount), 1);
    chk("after_rst_v", 32'(vif.vcount), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
